usb3_rx_sched: RTL

//  Read-side scheduler for the FT601 32-bit synchronous FIFO bridge, in the ftdi_clk domain.

---
 rtl/usb3_pkg.sv | 17 +
 rtl/usb3_rx_sched_if.sv | 30 +++
 rtl/usb3_rx_sched.sv | 113 +++++++++++
 3 files changed

// File: rtl/usb3_pkg.sv
// Shared FT601 bridge types: scheduler states, active-low strobe levels and default bus widths.
package usb3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OE_ON = 2'd1,
        READ  = 2'd2,
        GAP   = 2'd3
    } rx_state_t;

    localparam logic FT_ASSERT   = 1'b0;
    localparam logic FT_DEASSERT = 1'b1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;

endpackage

// File: rtl/usb3_rx_sched_if.sv
// FT601 read-side pins plus the downstream write-FIFO port; master is the scheduler side.
interface usb3_rx_sched_if
    import usb3_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DEF_BE_W
) ();

    logic              FT_RXF;
    logic              FT_OE;
    logic              FT_RD;
    logic [DATA_W-1:0] ft_data;
    logic [BE_W-1:0]   ft_be;

    logic              fifo_afull;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic [BE_W-1:0]   fifo_wr_be;

    modport master (
        input  FT_RXF, ft_data, ft_be, fifo_afull,
        output FT_OE, FT_RD, fifo_wr_en, fifo_wr_data, fifo_wr_be
    );

    modport slave (
        output FT_RXF, ft_data, ft_be, fifo_afull,
        input  FT_OE, FT_RD, fifo_wr_en, fifo_wr_data, fifo_wr_be
    );

endinterface

// File: rtl/usb3_rx_sched.sv
// FT601 read burst scheduler: OE turnaround, capped READ bursts, GAP spacing; 1-cycle word-to-write latency.
// Backpressure: fifo_afull blocks burst start and ends a burst after at most one further write.
module usb3_rx_sched
    import usb3_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BE_W      = DEF_BE_W,
    parameter int MAX_BURST = 1024,
    parameter int GAP_CYC   = 2,
    parameter int CNT_W     = 32
) (
    input  logic             ftdi_clk,
    input  logic             reset,
    input  logic             enable,
    usb3_rx_sched_if.master  bus,
    output logic             busy,
    output logic [CNT_W-1:0] word_count
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);

    rx_state_t         state;
    logic [BW-1:0]     burst_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              oe_q;
    logic              rd_q;
    logic              wr_en_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [BE_W-1:0]   wr_be_q;

    logic              capture;
    logic              stop;
    logic [BW-1:0]     burst_nxt;

    // Exit test uses the post-capture count so the word reaching MAX_BURST is still written.
    always_comb begin
        capture   = (state == READ) && (rd_q == FT_ASSERT) && (bus.FT_RXF == FT_ASSERT);
        burst_nxt = burst_cnt + BW'(capture);
        stop      = (bus.FT_RXF == FT_DEASSERT) || bus.fifo_afull || !enable ||
                    (burst_nxt == BURST_LAST);
    end

    always_ff @(posedge ftdi_clk) begin
        if (reset) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            gap_cnt    <= '0;
            oe_q       <= FT_DEASSERT;
            rd_q       <= FT_DEASSERT;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
            busy       <= 1'b0;
            word_count <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && (bus.FT_RXF == FT_ASSERT) && !bus.fifo_afull) begin
                        state <= OE_ON;
                        oe_q  <= FT_ASSERT;
                        busy  <= 1'b1;
                    end
                end
                OE_ON: begin
                    burst_cnt <= '0;
                    if (bus.FT_RXF == FT_DEASSERT) begin
                        state   <= GAP;
                        oe_q    <= FT_DEASSERT;
                        gap_cnt <= '0;
                    end else begin
                        state <= READ;
                        rd_q  <= FT_ASSERT;
                    end
                end
                READ: begin
                    if (capture) begin
                        wr_en_q    <= 1'b1;
                        wr_data_q  <= bus.ft_data;
                        wr_be_q    <= bus.ft_be;
                        word_count <= word_count + CNT_W'(1);
                        burst_cnt  <= burst_nxt;
                    end
                    if (stop) begin
                        state   <= GAP;
                        oe_q    <= FT_DEASSERT;
                        rd_q    <= FT_DEASSERT;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.FT_OE        = oe_q;
    assign bus.FT_RD        = rd_q;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign bus.fifo_wr_be   = wr_be_q;

endmodule
